// File: rtl/display_source_arbiter_pkg.sv
// Shared definitions for the display source arbiter and its scan prescaler.
// Holds the state and source encodings, the default timing parameters and the
// leading-zero blank helper.
package display_source_arbiter_pkg;

    localparam int unsigned DATA_W             = 16;
    localparam int unsigned MASK_W             = 4;
    localparam int unsigned SRC_W              = 2;
    localparam int unsigned DEFAULT_CLK_DIV    = 100000;
    localparam int unsigned DEFAULT_HOLD_TICKS = 2000;

    typedef enum logic [1:0] {
        S_CREDIT = 2'b00,
        S_PRICE  = 2'b01,
        S_MSG    = 2'b10
    } state_t;

    localparam logic [SRC_W-1:0] SRC_CREDIT = 2'b00;
    localparam logic [SRC_W-1:0] SRC_PRICE  = 2'b01;
    localparam logic [SRC_W-1:0] SRC_MSG    = 2'b10;

    // Blank leading zero digits; the least significant digit always shows.
    function automatic logic [MASK_W-1:0] leading_blank(input logic [DATA_W-1:0] value);
        logic [MASK_W-1:0] mask;
        mask[3] = (value[15:12] == 4'h0);
        mask[2] = mask[3] & (value[11:8] == 4'h0);
        mask[1] = mask[2] & (value[7:4] == 4'h0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/display_source_arbiter_scan_prescaler.sv
// Free-running divider producing the scan tick.
// Ports: clk, reset (async, active-high), tick (high while the count sits at
// CLK_DIV-1, i.e. once every CLK_DIV cycles).
module scan_prescaler
    import display_source_arbiter_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             at_top;

    assign at_top = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign tick   = at_top;

    // Count 0..CLK_DIV-1 and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (at_top) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_source_arbiter.sv
// Selects what the 4-digit display shows: running credit by default, a timed
// price preview, or a timed status message (highest priority).
// Ports: clk, reset (async, active-high); credit_bcd, price_req/price_bcd,
// msg_req/msg_code in; price_ack, msg_ack, disp_value, blank_mask, scan_en,
// src out (all registered).
module display_source_arbiter
    import display_source_arbiter_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] credit_bcd,
    input  logic              price_req,
    input  logic [DATA_W-1:0] price_bcd,
    input  logic              msg_req,
    input  logic [DATA_W-1:0] msg_code,
    output logic              price_ack,
    output logic              msg_ack,
    output logic [DATA_W-1:0] disp_value,
    output logic [MASK_W-1:0] blank_mask,
    output logic              scan_en,
    output logic [SRC_W-1:0]  src
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              price_ack_q, price_ack_d;
    logic              msg_ack_q, msg_ack_d;
    logic              scan_en_q;
    logic              tick;

    scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // State, hold counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CREDIT;
            hold_q      <= '0;
            disp_q      <= '0;
            mask_q      <= 4'b1110;
            price_ack_q <= 1'b0;
            msg_ack_q   <= 1'b0;
            scan_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            disp_q      <= disp_d;
            mask_q      <= mask_d;
            price_ack_q <= price_ack_d;
            msg_ack_q   <= msg_ack_d;
            scan_en_q   <= tick;
        end
    end

    // Arbitration: message > price > hold expiry > stay.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        disp_d      = disp_q;
        price_ack_d = 1'b0;
        msg_ack_d   = 1'b0;

        if (msg_req) begin
            state_d   = S_MSG;
            disp_d    = msg_code;
            hold_d    = HOLD_W'(HOLD_TICKS);
            msg_ack_d = 1'b1;
        end else begin
            case (state_q)
                S_CREDIT: begin
                    if (price_req) begin
                        state_d     = S_PRICE;
                        disp_d      = price_bcd;
                        hold_d      = HOLD_W'(HOLD_TICKS);
                        price_ack_d = 1'b1;
                    end else begin
                        disp_d = credit_bcd;
                    end
                end
                S_PRICE: begin
                    if (price_req) begin
                        disp_d      = price_bcd;
                        hold_d      = HOLD_W'(HOLD_TICKS);
                        price_ack_d = 1'b1;
                    end else if (tick) begin
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = S_CREDIT;
                            disp_d  = credit_bcd;
                        end
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                S_MSG: begin
                    // Price requests are dropped while a message is up.
                    if (tick) begin
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = S_CREDIT;
                            disp_d  = credit_bcd;
                        end
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = S_CREDIT;
                    disp_d  = credit_bcd;
                    hold_d  = '0;
                end
            endcase
        end

        // Messages are raw segment patterns, so never blank them.
        mask_d = (state_d == S_MSG) ? '0 : leading_blank(disp_d);
    end

    assign price_ack  = price_ack_q;
    assign msg_ack    = msg_ack_q;
    assign disp_value = disp_q;
    assign blank_mask = mask_q;
    assign scan_en    = scan_en_q;
    assign src        = state_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Randomized + directed bench for display_source_arbiter against a
// cycle-level behavioural model of the display rules.
module tb_display_source_arbiter;

    localparam int CLK_DIV    = 4;
    localparam int HOLD_TICKS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] credit_bcd;
    logic        price_req;
    logic [15:0] price_bcd;
    logic        msg_req;
    logic [15:0] msg_code;
    logic        price_ack;
    logic        msg_ack;
    logic [15:0] disp_value;
    logic [3:0]  blank_mask;
    logic        scan_en;
    logic [1:0]  src;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: mode 0 credit, 1 price, 2 message.
    int          m_k;
    int          m_mode;
    int          m_remain;
    logic [15:0] m_shown;
    logic        m_pack, m_mack, m_scan;

    display_source_arbiter #(.CLK_DIV(CLK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk        (clk),
        .reset      (reset),
        .credit_bcd (credit_bcd),
        .price_req  (price_req),
        .price_bcd  (price_bcd),
        .msg_req    (msg_req),
        .msg_code   (msg_code),
        .price_ack  (price_ack),
        .msg_ack    (msg_ack),
        .disp_value (disp_value),
        .blank_mask (blank_mask),
        .scan_en    (scan_en),
        .src        (src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Blank the run of leading zero digits, at most the top three.
    function automatic logic [3:0] model_mask(input int mode, input logic [15:0] v);
        logic [3:0] mk;
        int n;
        mk = 4'b0000;
        n  = 0;
        if (mode == 2) return 4'b0000;
        for (int d = 3; d >= 1; d--) begin
            if (v[d*4 +: 4] != 4'h0) break;
            n++;
        end
        for (int i = 0; i < n; i++) mk[3-i] = 1'b1;
        return mk;
    endfunction

    function automatic logic next_is_tick();
        return (m_k % CLK_DIV) == (CLK_DIV - 1);
    endfunction

    task automatic model_reset();
        m_k = 0; m_mode = 0; m_remain = 0; m_shown = 16'h0000;
        m_pack = 1'b0; m_mack = 1'b0; m_scan = 1'b0;
    endtask

    task automatic model_edge(input logic m, input logic [15:0] mc,
                              input logic p, input logic [15:0] pc,
                              input logic [15:0] cr);
        logic t;
        t = next_is_tick();
        m_k++;
        m_pack = 1'b0;
        m_mack = 1'b0;
        if (m) begin
            m_mode = 2; m_shown = mc; m_remain = HOLD_TICKS; m_mack = 1'b1;
        end else if (p && m_mode != 2) begin
            m_mode = 1; m_shown = pc; m_remain = HOLD_TICKS; m_pack = 1'b1;
        end else if (m_mode != 0 && t) begin
            m_remain--;
            if (m_remain == 0) m_mode = 0;
        end
        if (m_mode == 0) m_shown = cr;
        m_scan = t;
    endtask

    task automatic compare_all();
        check("src", 32'(src), 32'(m_mode));
        check("disp_value", 32'(disp_value), 32'(m_shown));
        check("blank_mask", 32'(blank_mask), 32'(model_mask(m_mode, m_shown)));
        check("price_ack", 32'(price_ack), 32'(m_pack));
        check("msg_ack", 32'(msg_ack), 32'(m_mack));
        check("scan_en", 32'(scan_en), 32'(m_scan));
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic step(input logic m, input logic [15:0] mc,
                        input logic p, input logic [15:0] pc);
        msg_req = m; msg_code = mc; price_req = p; price_bcd = pc;
        @(posedge clk);
        model_edge(m, mc, p, pc, credit_bcd);
        #1;
        compare_all();
        @(negedge clk);
        msg_req = 1'b0; price_req = 1'b0;
    endtask

    task automatic idle_until_credit(input string tag);
        int n;
        n = 0;
        while (m_mode != 0 && n < 40) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            n++;
        end
        if (m_mode != 0) check(tag, 32'd1, 32'd0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int unsigned nz;
        for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
        nz = $urandom_range(0, 4);
        for (int d = 0; d < 4; d++) if (d >= 4 - int'(nz)) v[d*4 +: 4] = 4'h0;
        return v;
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        credit_bcd = 16'h0025;
        price_req = 1'b0; price_bcd = 16'h0;
        msg_req = 1'b0; msg_code = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_src", 32'(src), 32'd0);
        check("rst_disp", 32'(disp_value), 32'h0);
        check("rst_mask", 32'(blank_mask), 32'he);
        check("rst_scan", 32'(scan_en), 32'd0);
        check("rst_acks", 32'({price_ack, msg_ack}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Credit display and scan pulses.
        repeat (9) step(1'b0, 16'h0, 1'b0, 16'h0);
        check("credit_0025", 32'({disp_value, blank_mask}), 32'({16'h0025, 4'b1100}));

        // Price preview then expiry back to credit.
        step(1'b0, 16'h0, 1'b1, 16'h0150);
        check("price_shown", 32'({src, disp_value, blank_mask}), 32'({2'b01, 16'h0150, 4'b1000}));
        idle_until_credit("price_expiry_timeout");

        // Message preempts price; price during message is dropped.
        step(1'b0, 16'h0, 1'b1, 16'h0150);
        step(1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 16'h00E1, 1'b0, 16'h0);
        check("msg_over_price", 32'({src, blank_mask}), 32'({2'b10, 4'b0000}));
        step(1'b0, 16'h0, 1'b1, 16'h0999);
        check("price_in_msg", 32'({src, price_ack}), 32'({2'b10, 1'b0}));
        idle_until_credit("msg_expiry_timeout");

        // Simultaneous requests: message only.
        step(1'b1, 16'h1234, 1'b1, 16'h0777);
        check("simultaneous", 32'({msg_ack, price_ack, src}), 32'({1'b1, 1'b0, 2'b10}));
        idle_until_credit("simul_expiry_timeout");

        // Price request on the exact expiry cycle keeps the preview up.
        step(1'b0, 16'h0, 1'b1, 16'h0042);
        n = 0;
        while (!(m_mode == 1 && m_remain == 1 && next_is_tick()) && n < 40) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            n++;
        end
        if (n >= 40) check("expiry_align_timeout", 32'd1, 32'd0);
        step(1'b0, 16'h0, 1'b1, 16'h0305);
        check("expiry_reload", 32'({src, disp_value}), 32'({2'b01, 16'h0305}));
        idle_until_credit("reload_expiry_timeout");

        // Reset asserted mid-message while scan_en is high.
        step(1'b1, 16'hABCD, 1'b0, 16'h0);
        n = 0;
        while (!m_scan && n < 10) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            n++;
        end
        check("pre_reset_src", 32'(src), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("midrst_src", 32'(src), 32'd0);
        check("midrst_disp", 32'(disp_value), 32'h0);
        check("midrst_mask", 32'(blank_mask), 32'he);
        check("midrst_scan", 32'(scan_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        rm, rp;
            logic [15:0] rmc, rpc;
            if ($urandom_range(0, 9) == 0) credit_bcd = rand_bcd();
            rm  = ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 7) == 0);
            rmc = 16'($urandom);
            rpc = rand_bcd();
            step(rm, rmc, rp, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares the 4-digit seven-segment display between three sources: running credit (default), item price preview (timed) and status/error message (timed, highest priority).
- Sits between the vending FSM and the digit-scan multiplexer.
- Drives the 16-bit BCD value, a leading-zero blank mask, and the scan-rate enable pulse that clocks digit rotation.

Parameters:
- CLK_DIV, 100000, clk cycles per scan tick; 1 kHz at 100 MHz; must be >= 2.
- HOLD_TICKS, 2000, scan ticks a price or message stays on display; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- credit_bcd  in  16  current credit, 4 BCD digits, [15:12] is the most significant digit
- price_req  in  1  single-cycle request to show price_bcd
- price_bcd  in  16  price to preview; sampled with price_req
- msg_req  in  1  single-cycle request to show msg_code
- msg_code  in  16  message/error pattern; sampled with msg_req
- price_ack  out  1  one-cycle pulse: price request accepted
- msg_ack  out  1  one-cycle pulse: message request accepted
- disp_value  out  16  value presented to the digit-scan mux
- blank_mask  out  4  1 = blank digit; bit i corresponds to nibble i
- scan_en  out  1  one-cycle pulse every CLK_DIV cycles
- src  out  2  active source: 00 credit, 01 price, 10 message

Behaviour:
- Reset (asynchronous): state S_CREDIT, src 00, disp_value 0000, blank_mask 1110, price_ack 0, msg_ack 0, scan_en 0, prescaler 0, hold_cnt 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - scan_en is registered and high for exactly one cycle, the cycle after the counter equals CLK_DIV-1.
  - Free-running in every state.
- States: S_CREDIT(00), S_PRICE(01), S_MSG(10). Encoding 11 is unused and recovers to S_CREDIT on the next clock.
- Priority per clock: msg_req > price_req > hold expiry > stay.
  - msg_req in any state: go to S_MSG, latch msg_code, hold_cnt <= HOLD_TICKS, msg_ack=1 next cycle. A msg_req during S_MSG restarts the hold.
  - price_req in S_CREDIT or S_PRICE: go to S_PRICE, latch price_bcd, hold_cnt <= HOLD_TICKS, price_ack=1 next cycle. A price_req during S_PRICE restarts the hold.
  - price_req in S_MSG: dropped, no ack.
  - msg_req and price_req in the same cycle: only the message is accepted; price_ack stays 0.
  - Hold: in S_PRICE/S_MSG, hold_cnt decrements on each internal tick (the cycle in which scan_en is being set). On the tick where hold_cnt==1, return to S_CREDIT.
  - A request arriving in the same cycle as expiry wins; its hold reloads.
- Latency: request sampled at edge N; at edge N+1 the ack pulse, src, disp_value and blank_mask all update together.
- S_CREDIT: disp_value tracks credit_bcd with one-cycle register latency.
- blank_mask, computed from the value being loaded into disp_value:
  - bit3 = nibble3==0.
  - bit2 = bit3 & nibble2==0.
  - bit1 = bit2 & nibble1==0.
  - bit0 is always 0.
  - In S_MSG, blank_mask is forced to 0000.
- Reset mid-hold: immediate return to reset values; any pending latched value is discarded.
- Acks never assert for two consecutive cycles from a single request pulse.

Decomposition:
- Shared package/include: state encodings, SRC_CREDIT/SRC_PRICE/SRC_MSG codes, default CLK_DIV and HOLD_TICKS.
- One sub-module, scan_prescaler (parameter CLK_DIV; ports clk, reset, tick). It is reused by other timed blocks.
- Arbitration FSM, hold counter and blank logic stay in this module.

Test Plan (CLK_DIV=4, HOLD_TICKS=3):
- Release reset with credit_bcd=0x0025 -> one cycle later disp_value=0x0025, blank_mask=1100, src=00; scan_en pulses every 4 cycles.
- price_req with price_bcd=0x0150 -> next cycle price_ack=1, src=01, disp_value=0x0150, blank_mask=1000. After the 3rd subsequent tick, src=00 and disp_value=credit.
- During S_PRICE, msg_req with msg_code=0x00E1 -> msg_ack=1, src=10, blank_mask=0000. A price_req during S_MSG gets no ack and src stays 10.
- Simultaneous msg_req and price_req in S_CREDIT -> msg_ack=1, price_ack=0, src=10.
- price_req on the exact expiry cycle -> stays in S_PRICE with the new value and the hold restarts at 3; no intermediate src=00 cycle.
- Assert reset mid-S_MSG -> src=00, disp_value=0000, blank_mask=1110, and scan_en=0 on the same cycle.
